// File: rtl/acu_reservation_station_if.sv
// Dispatch / broadcast / result bundle between the ROB and the ALU reservation station.
// Each result slot is a 37-bit word laid out as {tag[3:0], rdy, data[31:0]}.
interface acu_reservation_station_if #(
    parameter int size     = 8,
    parameter int rob_size = 8
);
    logic                         load_acu_rs;
    logic [3:0]                   rd_tag;
    logic [3:0]                   alu_op;
    logic                         is_reg;
    logic                         src1_valid;
    logic [31:0]                  src1_data;
    logic [3:0]                   src1_tag;
    logic                         src2_valid;
    logic [31:0]                  src2_data;
    logic [3:0]                   src2_tag;
    logic [rob_size-1:0][36:0]    rob_broadcast_bus;
    logic                         stall_acu;
    logic [size-1:0][36:0]        acu_rs_o;

    // ROB side: dispatches and broadcasts, observes stall and results
    modport master (
        output load_acu_rs, rd_tag, alu_op, is_reg,
        output src1_valid, src1_data, src1_tag,
        output src2_valid, src2_data, src2_tag,
        output rob_broadcast_bus,
        input  stall_acu, acu_rs_o
    );

    // Station side
    modport slave (
        input  load_acu_rs, rd_tag, alu_op, is_reg,
        input  src1_valid, src1_data, src1_tag,
        input  src2_valid, src2_data, src2_tag,
        input  rob_broadcast_bus,
        output stall_acu, acu_rs_o
    );
endinterface

// File: rtl/acu_reservation_station.sv
// ALU reservation station: holds dispatched op-imm/op-reg/auipc instructions,
// snoops the ROB broadcast bus for missing operands, and fires every entry
// whose operands are complete through its own ALU, one registered result per entry.
module acu_reservation_station #(
    parameter int size     = 8,
    parameter int rob_size = 8
) (
    input logic                      clk,
    input logic                      rst,
    acu_reservation_station_if.slave rs
);
    typedef struct packed {
        logic [3:0]  tag;
        logic        rdy;
        logic [31:0] data;
    } sal_t;

    // Per-entry state
    logic [size-1:0] busy_r;
    logic [size-1:0] is_reg_r;
    logic [size-1:0] v1_r;
    logic [size-1:0] v2_r;
    logic [3:0]      dest_r [size];
    logic [3:0]      op_r   [size];
    logic [31:0]     d1_r   [size];
    logic [31:0]     d2_r   [size];
    logic [3:0]      t1_r   [size];
    logic [3:0]      t2_r   [size];
    sal_t [size-1:0] out_r;

    logic            stall_s;
    logic [size-1:0] free_s;
    logic [size-1:0] alloc_s;
    logic [size-1:0] ready_s;
    logic [32:0]     cap1_s [size];
    logic [32:0]     cap2_s [size];
    logic [32:0]     disp1_s;
    logic [32:0]     disp2_s;

    // Returns {hit, data} for the lowest-index bus slot carrying a ready result for tag
    function automatic logic [32:0] snoop_f(input logic [3:0] tag,
                                            input logic [rob_size-1:0][36:0] bus);
        logic [32:0] r;
        r = 33'd0;
        for (int k = rob_size - 1; k >= 0; k--) begin
            r = (bus[k][32] && (bus[k][36:33] == tag)) ? {1'b1, bus[k][31:0]} : r;
        end
        return r;
    endfunction

    // RV32I integer ALU; op[3] is funct7[5], meaningful only for SUB and SRA
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic reg_op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op[2:0])
            3'd0: begin
                if (reg_op && op[3]) r = a - b;
                else                 r = a + b;
            end
            3'd1: r = a << b[4:0];
            3'd2: r = {31'd0, ($signed(a) < $signed(b))};
            3'd3: r = {31'd0, (a < b)};
            3'd4: r = a ^ b;
            3'd5: begin
                if (op[3]) r = $signed(a) >>> b[4:0];
                else       r = a >> b[4:0];
            end
            3'd6: r = a | b;
            3'd7: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Broadcast snooping for the dispatch path and for every held entry
    always_comb begin
        disp1_s = snoop_f(rs.src1_tag, rs.rob_broadcast_bus);
        disp2_s = snoop_f(rs.src2_tag, rs.rob_broadcast_bus);
        for (int i = 0; i < size; i++) begin
            cap1_s[i] = snoop_f(t1_r[i], rs.rob_broadcast_bus);
            cap2_s[i] = snoop_f(t2_r[i], rs.rob_broadcast_bus);
        end
    end

    // Allocation picks the lowest free entry; ready entries fire in parallel
    always_comb begin
        stall_s = &busy_r;
        free_s  = ~busy_r & (busy_r + {{(size-1){1'b0}}, 1'b1});
        ready_s = busy_r & v1_r & v2_r;
        if (rs.load_acu_rs && !stall_s) alloc_s = free_s;
        else                            alloc_s = {size{1'b0}};
    end

    // Entry state, operand capture, execute and one-cycle result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r   <= {size{1'b0}};
            is_reg_r <= {size{1'b0}};
            v1_r     <= {size{1'b0}};
            v2_r     <= {size{1'b0}};
            for (int i = 0; i < size; i++) begin
                dest_r[i] <= 4'd0;
                op_r[i]   <= 4'd0;
                d1_r[i]   <= 32'd0;
                d2_r[i]   <= 32'd0;
                t1_r[i]   <= 4'd0;
                t2_r[i]   <= 4'd0;
                out_r[i]  <= 37'd0;
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                if (ready_s[i]) begin
                    out_r[i]  <= {dest_r[i], 1'b1, alu_f(op_r[i], is_reg_r[i], d1_r[i], d2_r[i])};
                    busy_r[i] <= 1'b0;
                end else begin
                    out_r[i] <= 37'd0;
                    if (alloc_s[i]) begin
                        busy_r[i]   <= 1'b1;
                        dest_r[i]   <= rs.rd_tag;
                        op_r[i]     <= rs.alu_op;
                        is_reg_r[i] <= rs.is_reg;
                        t1_r[i]     <= rs.src1_tag;
                        t2_r[i]     <= rs.src2_tag;
                        if (rs.src1_valid) begin
                            v1_r[i] <= 1'b1;
                            d1_r[i] <= rs.src1_data;
                        end else begin
                            v1_r[i] <= disp1_s[32];
                            d1_r[i] <= disp1_s[31:0];
                        end
                        if (rs.src2_valid) begin
                            v2_r[i] <= 1'b1;
                            d2_r[i] <= rs.src2_data;
                        end else begin
                            v2_r[i] <= disp2_s[32];
                            d2_r[i] <= disp2_s[31:0];
                        end
                    end else if (busy_r[i]) begin
                        if (!v1_r[i] && cap1_s[i][32]) begin
                            v1_r[i] <= 1'b1;
                            d1_r[i] <= cap1_s[i][31:0];
                        end
                        if (!v2_r[i] && cap2_s[i][32]) begin
                            v2_r[i] <= 1'b1;
                            d2_r[i] <= cap2_s[i][31:0];
                        end
                    end
                end
            end
        end
    end

    assign rs.stall_acu = stall_s;
    assign rs.acu_rs_o  = out_r;
endmodule

// File: tb/tb_acu_reservation_station.sv
// Self-checking bench for acu_reservation_station: directed scenarios plus
// randomized dispatch/broadcast traffic compared against a cycle-level model.
module tb_acu_reservation_station;
    localparam int size     = 8;
    localparam int rob_size = 8;

    logic clk = 1'b0;
    logic rst;

    // 100 MHz clock
    always #5 clk = ~clk;

    acu_reservation_station_if #(.size(size), .rob_size(rob_size)) rs_if ();

    acu_reservation_station #(.size(size), .rob_size(rob_size)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model of the station: one record per entry plus expected result words
    bit          m_busy  [size];
    bit          m_isreg [size];
    bit          m_v1    [size];
    bit          m_v2    [size];
    logic [3:0]  m_dest  [size];
    logic [3:0]  m_op    [size];
    logic [31:0] m_d1    [size];
    logic [31:0] m_d2    [size];
    logic [3:0]  m_t1    [size];
    logic [3:0]  m_t2    [size];
    logic [36:0] m_out   [size];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU straight from the instruction semantics
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input bit isreg,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] l;
        sh = b[4:0];
        case (op[2:0])
            3'd0: return (isreg && op[3]) ? a + (~b + 32'd1) : a + b;
            3'd1: return a << sh;
            3'd2: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            3'd3: return {31'd0, (a < b)};
            3'd4: return a ^ b;
            3'd5: begin
                l = a >> sh;
                if (op[3] && a[31]) l = l | ~(32'hFFFF_FFFF >> sh);
                return l;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // First ready bus slot carrying tag, as {hit, data}
    function automatic logic [32:0] bus_find(input logic [3:0] tag);
        for (int k = 0; k < rob_size; k++) begin
            if (rs_if.rob_broadcast_bus[k][32] && rs_if.rob_broadcast_bus[k][36:33] == tag)
                return {1'b1, rs_if.rob_broadcast_bus[k][31:0]};
        end
        return 33'd0;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < size; i++) if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < size; i++) begin
            m_busy[i] = 0; m_v1[i] = 0; m_v2[i] = 0; m_out[i] = 37'd0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int slot;
        logic [32:0] h;
        slot = -1;
        for (int i = 0; i < size; i++) begin
            if (!m_busy[i]) begin slot = i; break; end
        end
        for (int i = 0; i < size; i++) begin
            if (m_busy[i] && m_v1[i] && m_v2[i]) begin
                m_out[i]  = {m_dest[i], 1'b1, ref_alu(m_op[i], m_isreg[i], m_d1[i], m_d2[i])};
                m_busy[i] = 0;
            end else begin
                m_out[i] = 37'd0;
                if (m_busy[i] && !m_v1[i]) begin
                    h = bus_find(m_t1[i]);
                    if (h[32]) begin m_v1[i] = 1; m_d1[i] = h[31:0]; end
                end
                if (m_busy[i] && !m_v2[i]) begin
                    h = bus_find(m_t2[i]);
                    if (h[32]) begin m_v2[i] = 1; m_d2[i] = h[31:0]; end
                end
            end
        end
        if (rs_if.load_acu_rs && slot >= 0) begin
            m_busy[slot]  = 1;
            m_dest[slot]  = rs_if.rd_tag;
            m_op[slot]    = rs_if.alu_op;
            m_isreg[slot] = rs_if.is_reg;
            m_t1[slot]    = rs_if.src1_tag;
            m_t2[slot]    = rs_if.src2_tag;
            h = bus_find(rs_if.src1_tag);
            m_v1[slot] = rs_if.src1_valid | h[32];
            m_d1[slot] = rs_if.src1_valid ? rs_if.src1_data : h[31:0];
            h = bus_find(rs_if.src2_tag);
            m_v2[slot] = rs_if.src2_valid | h[32];
            m_d2[slot] = rs_if.src2_valid ? rs_if.src2_data : h[31:0];
        end
    endtask

    task automatic drive_idle();
        rs_if.load_acu_rs       = 1'b0;
        rs_if.rob_broadcast_bus = '0;
    endtask

    task automatic drive_dispatch(input logic [3:0] tag, input logic [3:0] op, input bit isreg,
                                  input bit v1, input logic [31:0] d1, input logic [3:0] t1,
                                  input bit v2, input logic [31:0] d2, input logic [3:0] t2);
        check_eq("no_load_when_full", rs_if.stall_acu, 64'd0);
        rs_if.load_acu_rs = 1'b1;
        rs_if.rd_tag      = tag;
        rs_if.alu_op      = op;
        rs_if.is_reg      = isreg;
        rs_if.src1_valid  = v1;
        rs_if.src1_data   = d1;
        rs_if.src1_tag    = t1;
        rs_if.src2_valid  = v2;
        rs_if.src2_data   = d2;
        rs_if.src2_tag    = t2;
    endtask

    task automatic set_bus(input int k, input logic [3:0] tag, input logic [31:0] data);
        rs_if.rob_broadcast_bus[k] = {tag, 1'b1, data};
    endtask

    // One clock: model follows the edge, DUT compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("stall", rs_if.stall_acu, model_full());
        for (int i = 0; i < size; i++)
            check_eq($sformatf("out%0d", i), rs_if.acu_rs_o[i], m_out[i]);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        rs_if.rd_tag = 4'd0; rs_if.alu_op = 4'd0; rs_if.is_reg = 1'b0;
        rs_if.src1_valid = 1'b0; rs_if.src1_data = 32'd0; rs_if.src1_tag = 4'd0;
        rs_if.src2_valid = 1'b0; rs_if.src2_data = 32'd0; rs_if.src2_tag = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_stall", rs_if.stall_acu, 64'd0);
        for (int i = 0; i < size; i++)
            check_eq($sformatf("reset_out%0d", i), rs_if.acu_rs_o[i], 64'd0);
        rst = 1'b1;

        // Ready dispatch: ADD 7 + 0xFFFFFFFF
        drive_dispatch(4'd5, 4'b0000, 1'b1, 1'b1, 32'd7, 4'd0, 1'b1, 32'hFFFF_FFFF, 4'd0);
        step(); drive_idle();
        step();
        check_eq("add_t2", rs_if.acu_rs_o[0], {4'd5, 1'b1, 32'd6});
        step();
        check_eq("add_t3", rs_if.acu_rs_o[0], 64'd0);

        // Wake-up: SUB, src1 waits on tag 4, broadcast in cycle t+3
        drive_dispatch(4'd2, 4'b1000, 1'b1, 1'b0, 32'd0, 4'd4, 1'b1, 32'd3, 4'd0);
        step(); drive_idle();
        step();
        step();
        set_bus(0, 4'd4, 32'd10);
        step(); drive_idle();
        check_eq("sub_wait_t4", rs_if.acu_rs_o[0], 64'd0);
        step();
        check_eq("sub_t5", rs_if.acu_rs_o[0], {4'd2, 1'b1, 32'd7});

        // Same-cycle capture of SRAI operand, lowest matching bus slot wins
        drive_dispatch(4'd6, 4'b1101, 1'b0, 1'b0, 32'd0, 4'd1, 1'b1, 32'd4, 4'd0);
        set_bus(0, 4'd3, 32'h1234_5678);
        set_bus(1, 4'd1, 32'h8000_0000);
        set_bus(3, 4'd1, 32'h0000_0100);
        step(); drive_idle();
        step();
        check_eq("srai_capture", rs_if.acu_rs_o[0], {4'd6, 1'b1, 32'hF800_0000});

        // Full station: eight entries waiting on tag 9
        for (int i = 0; i < size; i++) begin
            drive_dispatch(4'(i), {1'b0, 3'(i)}, 1'b1, 1'b0, 32'd0, 4'd9,
                           (i % 3) != 0, 32'(i + 1), 4'd9);
            step();
        end
        drive_idle();
        check_eq("full_stall", rs_if.stall_acu, 64'd1);
        set_bus(5, 4'd9, 32'd1);
        step(); drive_idle();
        check_eq("full_still_stalled", rs_if.stall_acu, 64'd1);
        step();
        for (int i = 0; i < size; i++)
            check_eq($sformatf("full_rdy%0d", i), rs_if.acu_rs_o[i][32], 64'd1);
        check_eq("full_released", rs_if.stall_acu, 64'd0);
        step();

        // SLT versus SLTU on -1 vs 1
        drive_dispatch(4'd3, 4'b0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd1, 4'd0);
        step();
        drive_dispatch(4'd4, 4'b0011, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd1, 4'd0);
        step(); drive_idle();
        check_eq("slt", rs_if.acu_rs_o[0], {4'd3, 1'b1, 32'd1});
        step();
        check_eq("sltu", rs_if.acu_rs_o[1], {4'd4, 1'b0 | 1'b1, 32'd0});
        step();

        // Async reset with three waiting entries and a live result
        for (int i = 0; i < 3; i++) begin
            drive_dispatch(4'(10 + i), 4'b0100, 1'b0, 1'b0, 32'd0, 4'd14, 1'b1, 32'd5, 4'd0);
            step();
        end
        drive_dispatch(4'd13, 4'b0110, 1'b0, 1'b1, 32'h00F0, 4'd0, 1'b1, 32'h000F, 4'd0);
        step(); drive_idle();
        step();
        check_eq("pre_reset_rdy", rs_if.acu_rs_o[3][32], 64'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_reset_stall", rs_if.stall_acu, 64'd0);
        for (int i = 0; i < size; i++)
            check_eq($sformatf("async_reset_out%0d", i), rs_if.acu_rs_o[i], 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_dispatch(4'd7, 4'b0100, 1'b0, 1'b1, 32'hA5A5_0000, 4'd0, 1'b1, 32'h0000_5A5A, 4'd0);
        step(); drive_idle();
        step();
        check_eq("post_reset_entry0", rs_if.acu_rs_o[0], {4'd7, 1'b1, 32'hA5A5_5A5A});

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            drive_idle();
            if (!model_full() && $urandom_range(3) != 0)
                drive_dispatch(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(1) == 1,
                               $urandom, 4'($urandom), $urandom_range(1) == 1, $urandom, 4'($urandom));
            for (int k = 0; k < rob_size; k++)
                if ($urandom_range(3) == 0) set_bus(k, 4'($urandom), $urandom);
            step();
        end
        drive_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
